// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared widths, ALU function codes and the issue-entry record.
package alu_issue_pkg;
    localparam int DW_DEF = 32;
    localparam int FW_DEF = 6;
    localparam logic [FW_DEF-1:0] ALU_ADD  = 6'h20;
    localparam logic [FW_DEF-1:0] ALU_ADDU = 6'h21;
    localparam logic [FW_DEF-1:0] ALU_SUB  = 6'h22;
    localparam logic [FW_DEF-1:0] ALU_SUBU = 6'h23;
    localparam logic [FW_DEF-1:0] ALU_AND  = 6'h24;
    localparam logic [FW_DEF-1:0] ALU_OR   = 6'h25;
    localparam logic [FW_DEF-1:0] ALU_XOR  = 6'h26;
    localparam logic [FW_DEF-1:0] ALU_NOR  = 6'h27;
    localparam logic [FW_DEF-1:0] ALU_SLT  = 6'h2a;
    localparam logic [FW_DEF-1:0] ALU_SLTU = 6'h2b;
    typedef struct packed {
        logic [DW_DEF-1:0] a;
        logic [DW_DEF-1:0] b;
        logic [FW_DEF-1:0] f;
        logic [4:0]        rs_idx;
        logic [4:0]        rt_idx;
        logic [4:0]        rd_idx;
        logic              use_imm;
        logic              wen;
    } entry_t;
endpackage

// File: rtl/alu_issue_bypass.sv
// alu_issue_bypass: replaces entry operands with writeback data on index match.
// Active only when ALU_ISSUE_BYPASS_EN is defined; otherwise a pass-through.
module alu_issue_bypass
    import alu_issue_pkg::*;
(
    input  entry_t            e_i,
    input  logic              wb_en,
    input  logic [4:0]        wb_idx,
    input  logic [DW_DEF-1:0] wb_data,
    output entry_t            e_o
);
`ifdef ALU_ISSUE_BYPASS_EN
    logic hit_a, hit_b;
    always_comb begin
        hit_a = wb_en && wb_idx != 5'd0 && wb_idx == e_i.rs_idx;
        hit_b = wb_en && wb_idx != 5'd0 && !e_i.use_imm && wb_idx == e_i.rt_idx;
        e_o   = e_i;
        e_o.a = hit_a ? wb_data : e_i.a;
        e_o.b = hit_b ? wb_data : e_i.b;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_idx, wb_data};
    assign e_o = e_i;
`endif
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-entry (main + skid) ALU operand issue buffer with
// optional writeback bypass (ALU_ISSUE_BYPASS_EN).
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int FW = FW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_rs_data,
    input  logic [DW-1:0] in_rt_data,
    input  logic [4:0]    in_rs_idx,
    input  logic [4:0]    in_rt_idx,
    input  logic [4:0]    in_rd_idx,
    input  logic [15:0]   in_imm,
    input  logic          in_use_imm,
    input  logic          in_imm_sext,
    input  logic [FW-1:0] in_f,
    input  logic          in_wen,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [4:0]    wb_idx,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [FW-1:0] out_f,
    output logic [4:0]    out_rd_idx,
    output logic          out_wen
);
    entry_t main_q, main_d, skid_q, skid_d, raw, cap, main_bp, skid_bp;
    logic   main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
    logic   in_fire, out_fire;

    always_comb begin
        raw.a       = in_rs_data;
        raw.b       = in_use_imm ? (in_imm_sext ? {{(DW-16){in_imm[15]}}, in_imm}
                                                : {{(DW-16){1'b0}}, in_imm})
                                 : in_rt_data;
        raw.f       = in_f;
        raw.rs_idx  = in_rs_idx;
        raw.rt_idx  = in_rt_idx;
        raw.rd_idx  = in_rd_idx;
        raw.use_imm = in_use_imm;
        raw.wen     = in_wen;
    end

    alu_issue_bypass u_bp_cap  (.e_i(raw),    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .e_o(cap));
    alu_issue_bypass u_bp_main (.e_i(main_q), .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .e_o(main_bp));
    alu_issue_bypass u_bp_skid (.e_i(skid_q), .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .e_o(skid_bp));

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = main_v_q && out_ready;

    // Invalid slots keep their old contents so outputs hold while out_valid=0.
    always_comb begin
        main_d   = main_v_q ? main_bp : main_q;
        skid_d   = skid_v_q ? skid_bp : skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (out_fire || !main_v_q) begin
            if (skid_v_q) begin
                main_d   = skid_bp;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_fire;
                main_d   = in_fire ? cap : main_d;
            end
        end else if (in_fire) begin
            skid_d   = cap;
            skid_v_d = 1'b1;
        end
        in_ready_d = !skid_v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_v_q;
    assign out_a      = main_q.a;
    assign out_b      = main_q.b;
    assign out_f      = main_q.f;
    assign out_rd_idx = main_q.rd_idx;
    assign out_wen    = main_q.wen;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_rs_data = '0, in_rt_data = '0;
    logic [4:0]  in_rs_idx = '0, in_rt_idx = '0, in_rd_idx = '0;
    logic [15:0] in_imm = '0;
    logic        in_use_imm = 1'b0, in_imm_sext = 1'b0;
    logic [5:0]  in_f = '0;
    logic        in_wen = 1'b0, flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_idx = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_a, out_b;
    logic [5:0]  out_f;
    logic [4:0]  out_rd_idx;
    logic        out_wen;
    int          errors = 0, checks = 0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_rs_idx(in_rs_idx),
        .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_imm_sext(in_imm_sext), .in_f(in_f),
        .in_wen(in_wen), .flush(flush), .wb_en(wb_en), .wb_idx(wb_idx),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_f(out_f), .out_rd_idx(out_rd_idx),
        .out_wen(out_wen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] rsi, input logic [4:0] rti, input logic [4:0] rdi);
        in_valid   = 1'b1;
        in_rs_data = rs;
        in_rt_data = rt;
        in_rs_idx  = rsi;
        in_rt_idx  = rti;
        in_rd_idx  = rdi;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_tags", {20'd0, out_f, out_rd_idx, out_wen}, 32'd0);
        step();
        rst_n = 1'b1;
        // Single entry through an empty stage: one cycle latency.
        in_f = 6'h20;
        in_wen = 1'b1;
        drive(32'h5, 32'h3, 5'd1, 5'd2, 5'd7);
        step();
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_a", out_a, 32'h5);
        chk("lat_b", out_b, 32'h3);
        chk("lat_tags", {20'd0, out_f, out_rd_idx, out_wen}, {20'd0, 6'h20, 5'd7, 1'b1});
        in_valid = 1'b0;
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_a", out_a, 32'h5);
        // Immediate extension, back-to-back with out_ready=1.
        in_use_imm = 1'b1;
        in_imm = 16'hFFFE;
        in_imm_sext = 1'b1;
        drive(32'h9, 32'h3, 5'd1, 5'd2, 5'd8);
        step();
        chk("imm_sext", out_b, 32'hFFFF_FFFE);
        in_imm_sext = 1'b0;
        step();
        chk("imm_zext", out_b, 32'h0000_FFFE);
        chk("pass_valid", {31'd0, out_valid}, 32'd1);
        chk("pass_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        in_use_imm = 1'b0;
        step();
        chk("imm_drain", {31'd0, out_valid}, 32'd0);
        // Backpressure: two held, third stalled, then released in order.
        out_ready = 1'b0;
        drive(32'h11, 32'h0, 5'd1, 5'd2, 5'd3);
        step();
        chk("bp1_a", out_a, 32'h11);
        chk("bp1_in_ready", {31'd0, in_ready}, 32'd1);
        drive(32'h22, 32'h0, 5'd1, 5'd2, 5'd3);
        step();
        chk("bp2_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp2_a", out_a, 32'h11);
        drive(32'h33, 32'h0, 5'd1, 5'd2, 5'd3);
        step();
        chk("bp3_a", out_a, 32'h11);
        chk("bp3_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("rel1_a", out_a, 32'h22);
        chk("rel1_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("rel2_a", out_a, 32'h33);
        chk("rel2_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        chk("rel3_valid", {31'd0, out_valid}, 32'd0);
        // Bypass onto a held entry.
        out_ready = 1'b0;
        drive(32'h100, 32'h200, 5'd4, 5'd5, 5'd9);
        step();
        chk("byp_cap_a", out_a, 32'h100);
        in_valid = 1'b0;
        wb_en = 1'b1;
        wb_idx = 5'd4;
        wb_data = 32'hDEAD_BEEF;
        step();
`ifdef ALU_ISSUE_BYPASS_EN
        chk("byp_held_a", out_a, 32'hDEAD_BEEF);
`else
        chk("byp_held_a", out_a, 32'h100);
`endif
        chk("byp_held_b", out_b, 32'h200);
        wb_en = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush1_valid", {31'd0, out_valid}, 32'd0);
        // Index 0 never matches, at capture or while held.
        wb_en = 1'b1;
        wb_idx = 5'd0;
        drive(32'h55, 32'h66, 5'd0, 5'd0, 5'd1);
        step();
        chk("idx0_cap_a", out_a, 32'h55);
        chk("idx0_cap_b", out_b, 32'h66);
        in_valid = 1'b0;
        step();
        chk("idx0_held_a", out_a, 32'h55);
        wb_en = 1'b0;
        // Flush with two held and an input offered.
        drive(32'h77, 32'h0, 5'd1, 5'd2, 5'd3);
        step();
        chk("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        drive(32'h99, 32'h0, 5'd1, 5'd2, 5'd3);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("fl_absent", {31'd0, out_valid}, 32'd0);
        // Reset with entries held.
        out_ready = 1'b0;
        drive(32'hA1, 32'hB1, 5'd1, 5'd2, 5'd3);
        step();
        drive(32'hA2, 32'hB2, 5'd1, 5'd2, 5'd3);
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mr_a", out_a, 32'd0);
        chk("mr_b", out_b, 32'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mr_no_stale", {31'd0, out_valid}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter DW, default 32: operand/data width.
REQ-002 Parameter FW, default 6: ALU function-code width, matching the ALU F input.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  upstream decode entry valid.
REQ-006 in_ready  out  1  stage can accept an entry this cycle.
REQ-007 in_rs_data, in_rt_data  in  DW each  register-file read values.
REQ-008 in_rs_idx, in_rt_idx, in_rd_idx  in  5 each  source/destination register indices.
REQ-009 in_imm  in  16  immediate field.
REQ-010 in_use_imm, in_imm_sext  in  1 each  B selects immediate; sign- (1) or zero- (0) extend.
REQ-011 in_f  in  FW  ALU function code.
REQ-012 in_wen  in  1  entry writes rd.
REQ-013 flush  in  1  discard all held entries.
REQ-014 wb_en, wb_idx (5), wb_data (DW)  in  writeback bypass port.
REQ-015 out_valid  out  1;  out_ready  in  1  downstream handshake.
REQ-016 out_a, out_b  out  DW; out_f  out  FW; out_rd_idx  out  5; out_wen  out  1  ALU operands and tags.

Function
REQ-017 Transfer in occurs when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-018 Storage SHALL be a main register plus one skid register (2 entries max); in_ready SHALL be a registered signal equal to "skid empty".
REQ-019 Latency in->out SHALL be exactly 1 cycle when the stage is empty and out_ready=1.
REQ-020 Accepted entry SHALL go to main if main empty or draining this cycle, else to skid; skid SHALL move to main on the cycle main drains.
REQ-021 Order SHALL be preserved; no entry dropped or duplicated except by flush.
REQ-022 B at capture SHALL be: in_use_imm ? extend(in_imm) : in_rt_data; extension to DW per in_imm_sext.
REQ-023 Bypass at capture: if wb_en & wb_idx!=0 & wb_idx==in_rs_idx, A SHALL take wb_data; same for B when in_use_imm=0 and wb_idx==in_rt_idx.
REQ-024 Bypass while held: each cycle, a held entry's A/B (B only if not immediate) SHALL be overwritten by wb_data on the same index match; index 0 never matches.
REQ-025 out_* SHALL reflect the main register; out_a/out_b/out_f/out_rd_idx/out_wen are don't-care-stable (hold last value) when out_valid=0.
REQ-026 flush SHALL clear both valid bits next edge; an input offered in the flush cycle SHALL be dropped; in_ready SHALL be 1 the following cycle.
REQ-027 Simultaneous in and out transfer with main full and skid empty SHALL keep occupancy unchanged.

Reset
REQ-028 While rst_n=0: out_valid=0, in_ready=1, out_a=0, out_b=0, out_f=0, out_rd_idx=0, out_wen=0, skid empty.
REQ-029 Reset mid-transfer SHALL discard all held entries; first accept possible on first edge after rst_n rises.

Configuration
REQ-030 Macro ALU_ISSUE_BYPASS_EN: defined, REQ-023/024 bypass active; undefined, wb_* ports remain but are ignored and operands are exactly the captured register-file/immediate values.

Structure
REQ-031 Shared package SHALL hold DW/FW defaults, the ALU function-code constants, and the issue-entry record (a, b, f, rs_idx, rt_idx, rd_idx, use_imm, wen).
REQ-032 One sub-module, alu_issue_bypass, SHALL implement the index-compare/operand-replace logic, instantiated for capture and for each held entry.

Verification
REQ-033 Empty stage, in rs=0x0000_0005, rt=0x0000_0003, f=add, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=3.
REQ-034 in_use_imm=1, imm=0xFFFE, sext=1 -> out_b=0xFFFF_FFFE; sext=0 -> 0x0000_FFFE.
REQ-035 out_ready=0, three back-to-back inputs -> first two held, in_ready=0 after second; release -> outputs in order, no loss.
REQ-036 Held entry rs_idx=4, wb_en=1 wb_idx=4 wb_data=0xDEAD_BEEF -> out_a=0xDEAD_BEEF (macro defined), unchanged (undefined); wb_idx=0 -> never replaced.
REQ-037 Two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flush-cycle input absent.
REQ-038 rst_n low during held entries -> all outputs at REQ-028 values immediately, no stale output after release.
